// File: rtl/baud_tick_gen.sv
// Fractional baud strobe generator: oversampled rx tick with sync/phase/mid-bit sample, plus tx bit tick.
// Latency: strobes registered, 1 cycle wide; no backpressure (free-running clock enables gated by enable).
module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 31250,
    parameter int unsigned OVERSAMPLE = 8,
    localparam int unsigned PH_W      = $clog2(OVERSAMPLE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            rx_sync,
    output logic            rx_tick,
    output logic [PH_W-1:0] rx_phase,
    output logic            rx_sample,
    output logic            tx_tick
);

    localparam longint unsigned S_RX_L = longint'(BAUD) * longint'(OVERSAMPLE);
    localparam int unsigned     ACC_W  = $clog2(CLK_HZ) + 1;
    localparam int unsigned     SUM_W  = ACC_W + 1;

    if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("baud_tick_gen: OVERSAMPLE must be even and >= 2");
    end
    if (BAUD == 0 || 2 * S_RX_L > 64'hFFFF_FFFF || 2 * S_RX_L > longint'(CLK_HZ)) begin : g_bad_ratio
        $error("baud_tick_gen: need 2*BAUD*OVERSAMPLE <= CLK_HZ within 32 bits");
    end

    localparam logic [SUM_W-1:0] MOD      = SUM_W'(CLK_HZ);
    localparam logic [SUM_W-1:0] S_RX     = SUM_W'(S_RX_L);
    localparam logic [SUM_W-1:0] S_TX     = SUM_W'(BAUD);
    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]  MID_PH   = PH_W'(OVERSAMPLE / 2 - 1);

    logic [ACC_W-1:0] acc_rx_q, acc_rx_d;
    logic [ACC_W-1:0] acc_tx_q, acc_tx_d;
    logic [PH_W-1:0]  rx_phase_q, rx_phase_d;
    logic             rx_tick_q, rx_tick_d;
    logic             rx_sample_q, rx_sample_d;
    logic             tx_tick_q, tx_tick_d;
    logic [SUM_W-1:0] rx_sum, tx_sum;
    logic [PH_W-1:0]  rx_phase_inc;

    // Sums are one bit wider than the accumulators so the wrap compare never overflows.
    assign rx_sum       = {1'b0, acc_rx_q} + S_RX;
    assign tx_sum       = {1'b0, acc_tx_q} + S_TX;
    assign rx_phase_inc = (rx_phase_q == LAST_PH) ? '0 : rx_phase_q + PH_W'(1);

    always_comb begin
        acc_rx_d    = acc_rx_q;
        acc_tx_d    = acc_tx_q;
        rx_phase_d  = rx_phase_q;
        rx_tick_d   = 1'b0;
        rx_sample_d = 1'b0;
        tx_tick_d   = 1'b0;
        if (enable) begin
            if (tx_sum >= MOD) begin
                acc_tx_d  = ACC_W'(tx_sum - MOD);
                tx_tick_d = 1'b1;
            end else begin
                acc_tx_d  = ACC_W'(tx_sum);
            end
            // A sync restarts the rx bit frame and swallows any tick due this cycle.
            if (rx_sync) begin
                acc_rx_d   = '0;
                rx_phase_d = LAST_PH;
            end else if (rx_sum >= MOD) begin
                acc_rx_d    = ACC_W'(rx_sum - MOD);
                rx_tick_d   = 1'b1;
                rx_phase_d  = rx_phase_inc;
                rx_sample_d = (rx_phase_inc == MID_PH);
            end else begin
                acc_rx_d    = ACC_W'(rx_sum);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_rx_q    <= '0;
            acc_tx_q    <= '0;
            rx_phase_q  <= LAST_PH;
            rx_tick_q   <= 1'b0;
            rx_sample_q <= 1'b0;
            tx_tick_q   <= 1'b0;
        end else begin
            acc_rx_q    <= acc_rx_d;
            acc_tx_q    <= acc_tx_d;
            rx_phase_q  <= rx_phase_d;
            rx_tick_q   <= rx_tick_d;
            rx_sample_q <= rx_sample_d;
            tx_tick_q   <= tx_tick_d;
        end
    end

    assign rx_tick   = rx_tick_q;
    assign rx_phase  = rx_phase_q;
    assign rx_sample = rx_sample_q;
    assign tx_tick   = tx_tick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: default instance driven by tables/sequences/random stimulus,
// plus a free-running fractional-ratio instance, both against floor(K*S/CLK_HZ) models.
module tb_baud_tick_gen;

    localparam longint C   = 12000000;
    localparam longint SR  = 250000;
    localparam longint ST  = 31250;
    localparam int     OS  = 8;
    localparam longint SR2 = 115200 * 16;
    localparam longint ST2 = 115200;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rx_sync;
    logic       rx_tick, rx_sample, tx_tick;
    logic [2:0] rx_phase;
    logic       f_enable = 1'b1;
    logic       f_sync   = 1'b0;
    logic       f_rx_tick, f_rx_sample, f_tx_tick;
    logic [3:0] f_rx_phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    baud_tick_gen dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_sync(rx_sync),
        .rx_tick(rx_tick), .rx_phase(rx_phase), .rx_sample(rx_sample), .tx_tick(tx_tick)
    );

    baud_tick_gen #(.CLK_HZ(12000000), .BAUD(115200), .OVERSAMPLE(16)) dut_frac (
        .clk(clk), .reset(reset), .enable(f_enable), .rx_sync(f_sync),
        .rx_tick(f_rx_tick), .rx_phase(f_rx_phase), .rx_sample(f_rx_sample), .tx_tick(f_tx_tick)
    );

    function automatic bit crossed(input longint k, input longint s);
        return ((k * s) / C) != (((k - 1) * s) / C);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for the default instance: tick count is floor(K*S/CLK_HZ)
    // over enabled edges K since reset (tx) or since reset/sync (rx).
    longint k_rx, k_tx;
    int     n_rx, e_ph;
    bit     e_rx, e_tx, e_smp;
    int     obs_rx, obs_tx, obs_smp;

    task automatic model_reset();
        k_rx = 0; k_tx = 0; n_rx = 0; e_ph = OS - 1;
        e_rx = 0; e_tx = 0; e_smp = 0;
    endtask

    task automatic step(input bit en, input bit sy);
        enable  = en;
        rx_sync = sy;
        @(posedge clk);
        e_rx = 0; e_tx = 0; e_smp = 0;
        if (en) begin
            k_tx++;
            e_tx = crossed(k_tx, ST);
            if (sy) begin
                k_rx = 0; n_rx = 0; e_ph = OS - 1;
            end else begin
                k_rx++;
                e_rx = crossed(k_rx, SR);
                if (e_rx) begin
                    n_rx++;
                    e_ph  = (OS - 1 + n_rx) % OS;
                    e_smp = (e_ph == OS / 2 - 1);
                end
            end
        end
        @(negedge clk);
        check("strobes{rx,phase,smp,tx}", {rx_tick, rx_phase, rx_sample, tx_tick},
              {e_rx, 3'(e_ph), e_smp, e_tx});
        obs_rx  += int'(rx_tick);
        obs_tx  += int'(tx_tick);
        obs_smp += int'(rx_sample);
    endtask

    // Fractional instance: always enabled, never synced.
    longint k2, tot2;
    int     n2, last2, cyc2;
    bit     e2_rx, e2_tx, e2_smp;
    int     e2_ph;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k2 = 0; n2 = 0; e2_rx = 0; e2_tx = 0; e2_smp = 0; e2_ph = 15;
        end else begin
            k2++;
            e2_rx = crossed(k2, SR2);
            e2_tx = crossed(k2, ST2);
            e2_smp = 0;
            if (e2_rx) begin
                n2++;
                e2_ph  = (15 + n2) % 16;
                e2_smp = (e2_ph == 7);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            last2 = -1; cyc2 = 0; tot2 = 0;
        end else if (k2 > 0) begin
            cyc2++;
            check("frac_strobes{rx,phase,smp,tx}", {f_rx_tick, f_rx_phase, f_rx_sample, f_tx_tick},
                  {e2_rx, 4'(e2_ph), e2_smp, e2_tx});
            if (f_rx_tick) begin
                tot2++;
                if (last2 >= 0) begin
                    checks++;
                    if (cyc2 - last2 < 6 || cyc2 - last2 > 7) begin
                        errors++;
                        $display("FAIL frac_gap: got %0d expected 6 or 7", cyc2 - last2);
                    end
                end
                last2 = cyc2;
            end
        end
    end

    typedef struct {
        bit en;
        bit sy;
        int len;
        int rx;
        int tx;
        int smp;
        int ph;
    } seg_t;

    seg_t tbl[13];

    initial begin
        int first_rx, first_tx;
        bit seen;

        // Segments run back to back from reset: {en, sync on first cycle, length, rx/tx/sample counts, end phase}.
        tbl[0]  = '{1, 0,  48, 1, 0, 0, 0};
        tbl[1]  = '{1, 0,  20, 0, 0, 0, 0};
        tbl[2]  = '{1, 1,  48, 0, 0, 0, 7};
        tbl[3]  = '{1, 0,   1, 1, 0, 0, 0};
        tbl[4]  = '{1, 0, 144, 3, 0, 1, 3};
        tbl[5]  = '{1, 0,  38, 0, 0, 0, 3};
        tbl[6]  = '{0, 1, 100, 0, 0, 0, 3};
        tbl[7]  = '{1, 0,   9, 0, 0, 0, 3};
        tbl[8]  = '{1, 0,   1, 1, 0, 0, 4};
        tbl[9]  = '{1, 0,  75, 1, 1, 0, 5};
        tbl[10] = '{1, 0,  20, 0, 0, 0, 5};
        tbl[11] = '{1, 1,   1, 0, 0, 0, 7};
        tbl[12] = '{1, 0,  48, 1, 0, 0, 0};

        reset = 1'b1; enable = 1'b0; rx_sync = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {rx_tick, rx_phase, rx_sample, tx_tick}, {1'b0, 3'd7, 1'b0, 1'b0});
        reset = 1'b0;
        model_reset();

        for (int s = 0; s < 13; s++) begin
            obs_rx = 0; obs_tx = 0; obs_smp = 0;
            for (int c = 0; c < tbl[s].len; c++)
                step(tbl[s].en, tbl[s].sy && (c == 0));
            check($sformatf("seg%0d_rx", s), obs_rx, tbl[s].rx);
            check($sformatf("seg%0d_tx", s), obs_tx, tbl[s].tx);
            check($sformatf("seg%0d_smp", s), obs_smp, tbl[s].smp);
            check($sformatf("seg%0d_phase", s), rx_phase, tbl[s].ph);
        end

        // Asynchronous reset landing in the middle of an rx_tick high cycle.
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(1, 0);
            seen = e_rx;
        end
        check("tick_before_reset", {rx_tick, seen}, 2'b11);
        #2 reset = 1'b1;
        #1 check("async_reset", {rx_tick, rx_phase, rx_sample, tx_tick}, {1'b0, 3'd7, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // 4000 enabled cycles from reset.
        obs_rx = 0; obs_tx = 0; obs_smp = 0;
        first_rx = -1; first_tx = -1;
        for (int c = 1; c <= 4000; c++) begin
            step(1, 0);
            if (rx_tick && first_rx < 0) first_rx = c;
            if (tx_tick && first_tx < 0) first_tx = c;
        end
        check("first_rx_cycle", first_rx, 48);
        check("first_tx_cycle", first_tx, 384);
        check("rx_count_4000", obs_rx, 83);
        check("tx_count_4000", obs_tx, 10);
        check("smp_count_4000", obs_smp, 10);

        for (int i = 0; i < 20000; i++)
            step(($urandom % 8) != 0, ($urandom % 50) == 0);

        check("frac_total_rx", tot2, (k2 * SR2) / C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
